// File: rtl/int_ctrl_pkg.sv
// Shared constants for the external interrupt controller.
// Register offsets, claim word layout and CPU line indices.
package int_ctrl_pkg;

  localparam int INTC_CPU_LINES   = 6;
  localparam int INTC_TIMER_LINE  = 5;
  localparam int INTC_ROUTE_LINES = 5;
  localparam int INTC_CLAIM_VLD   = 31;

  localparam logic [2:0] INTC_REG_PENDING = 3'd0;
  localparam logic [2:0] INTC_REG_MASK    = 3'd1;
  localparam logic [2:0] INTC_REG_MODE    = 3'd2;
  localparam logic [2:0] INTC_REG_CLEAR   = 3'd3;
  localparam logic [2:0] INTC_REG_CLAIM   = 3'd4;
  localparam logic [2:0] INTC_REG_RAW     = 3'd5;

  function automatic logic [31:0] claim_word(
    input logic       hit,
    input logic [4:0] idx
  );
    logic [31:0] w;
    w = '0;
    if (hit) begin
      w[INTC_CLAIM_VLD] = 1'b1;
      w[4:0] = idx;
    end
    return w;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-stage synchroniser for asynchronous interrupt lines.
// Clears asynchronously so every stage reads 0 right after reset.
module irq_sync #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [STAGES-1:0][W-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain[STAGES-1];

endmodule

// File: rtl/int_ctrl.sv
// External interrupt controller feeding the CP0 int_i lines.
// Level/edge detection, masking, claim port and timer passthrough.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic               timer_i,
  input  logic               we_i,
  input  logic               re_i,
  input  logic [4:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic [5:0]         int_o
);

  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] mode;
  logic [NUM_SRC-1:0] ep;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] pm;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] claim_oh;
  logic [NUM_SRC-1:0] mask_nxt;
  logic [NUM_SRC-1:0] mode_nxt;
  logic [NUM_SRC-1:0] ep_nxt;

  logic [2:0]  sel;
  logic        sel_pend;
  logic        sel_mask;
  logic        sel_mode;
  logic        sel_clr;
  logic        sel_claim;
  logic        sel_raw;
  logic        claim_hit;
  logic [4:0]  claim_idx;
  logic        claim_rd;
  logic [4:0]  route;
  logic [31:0] rd_mux;

  irq_sync #(
    .W      (NUM_SRC),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (irq_i),
    .q_o (s)
  );

  assign sel       = addr_i[4:2];
  assign sel_pend  = (sel == INTC_REG_PENDING);
  assign sel_mask  = (sel == INTC_REG_MASK);
  assign sel_mode  = (sel == INTC_REG_MODE);
  assign sel_clr   = (sel == INTC_REG_CLEAR);
  assign sel_claim = (sel == INTC_REG_CLAIM);
  assign sel_raw   = (sel == INTC_REG_RAW);

  assign rise = s & ~d;
  assign pend = (mode & ep) | (~mode & s);
  assign pm   = pend & mask;

  // Lowest index wins: scan downward so the last hit is the lowest.
  always_comb begin
    claim_hit = 1'b0;
    claim_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pm[i]) begin
        claim_hit = 1'b1;
        claim_idx = 5'(i);
      end
    end
  end

  assign claim_rd = re_i & sel_claim & claim_hit;

  always_comb begin
    claim_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_oh[i] = claim_rd & (claim_idx == 5'(i));
    end
  end

  assign clr = claim_oh
             | ({NUM_SRC{we_i & sel_clr}} & wdata_i[NUM_SRC-1:0]);

  assign mask_nxt = (we_i & sel_mask) ? wdata_i[NUM_SRC-1:0] : mask;
  assign mode_nxt = (we_i & sel_mode) ? wdata_i[NUM_SRC-1:0] : mode;

  // New events override clears; leaving edge mode drops the bit.
  assign ep_nxt = ((ep & ~clr) | (rise & mode)) & mode_nxt;

  always_comb begin
    route = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < INTC_ROUTE_LINES; k++) begin
        if ((i % INTC_ROUTE_LINES) == k) begin
          route[k] = route[k] | pm[i];
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_pend:  rd_mux = 32'(pend);
      sel_mask:  rd_mux = 32'(mask);
      sel_mode:  rd_mux = 32'(mode);
      sel_clr:   rd_mux = '0;
      sel_claim: rd_mux = claim_word(claim_hit, claim_idx);
      sel_raw:   rd_mux = 32'(s);
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d       <= '0;
      mask    <= '0;
      mode    <= '0;
      ep      <= '0;
      int_o   <= '0;
      rdata_o <= '0;
    end else begin
      d     <= s;
      mask  <= mask_nxt;
      mode  <= mode_nxt;
      ep    <= ep_nxt;
      int_o <= {timer_i, route};
      if (re_i) begin
        rdata_o <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: history-based reference model,
// directed scenarios, then randomized traffic.
module tb_int_ctrl;

  localparam int NS = 8;
  localparam int ST = 2;

  localparam logic [2:0] R_PEND  = 3'd0;
  localparam logic [2:0] R_MASK  = 3'd1;
  localparam logic [2:0] R_MODE  = 3'd2;
  localparam logic [2:0] R_CLEAR = 3'd3;
  localparam logic [2:0] R_CLAIM = 3'd4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NS-1:0] irq_i = '0;
  logic          timer_i = 1'b0;
  logic          we_i = 1'b0;
  logic          re_i = 1'b0;
  logic [4:0]    addr_i = '0;
  logic [31:0]   wdata_i = '0;
  logic [31:0]   rdata_o;
  logic [5:0]    int_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_q[$];
  logic [5:0]  int_q[$];
  logic [31:0] dir_v[$];
  bit          dir_c[$];
  string       dir_n[$];

  logic [NS-1:0] m_mask;
  logic [NS-1:0] m_mode;
  logic [NS-1:0] m_ep;
  logic [NS-1:0] hist[$];

  always #5 clk = ~clk;

  int_ctrl #(
    .NUM_SRC     (NS),
    .SYNC_STAGES (ST)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_i   (irq_i),
    .timer_i (timer_i),
    .we_i    (we_i),
    .re_i    (re_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .int_o   (int_o)
  );

  task automatic check32(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mask = '0;
    m_mode = '0;
    m_ep   = '0;
    hist.delete();
    for (int i = 0; i <= ST; i++) hist.push_back('0);
    rd_q.delete();
    int_q.delete();
    dir_v.delete();
    dir_c.delete();
    dir_n.delete();
  endtask

  // Synchronised value = input seen ST edges back; delayed = ST+1.
  task automatic model_step();
    logic [NS-1:0] s, d, rise, pend, pm, clr, nmask, nmode;
    logic [5:0]    io;
    logic [2:0]    sel;
    int            idx;
    s    = hist[ST-1];
    d    = hist[ST];
    rise = s & ~d;
    pend = (m_mode & m_ep) | (~m_mode & s);
    pm   = pend & m_mask;
    idx  = -1;
    for (int i = 0; i < NS; i++) if (pm[i] && idx < 0) idx = i;
    sel = addr_i[4:2];
    if (re_i) begin
      case (sel)
        3'd0:    rd_q.push_back(32'(pend));
        3'd1:    rd_q.push_back(32'(m_mask));
        3'd2:    rd_q.push_back(32'(m_mode));
        3'd4:    rd_q.push_back(idx >= 0 ? (32'h8000_0000 | 32'(idx)) : 32'h0);
        3'd5:    rd_q.push_back(32'(s));
        default: rd_q.push_back(32'h0);
      endcase
    end
    clr = '0;
    if (we_i && sel == 3'd3) clr = wdata_i[NS-1:0];
    if (re_i && sel == 3'd4 && idx >= 0) clr[idx] = 1'b1;
    nmask = (we_i && sel == 3'd1) ? wdata_i[NS-1:0] : m_mask;
    nmode = (we_i && sel == 3'd2) ? wdata_i[NS-1:0] : m_mode;
    io = '0;
    for (int i = 0; i < NS; i++) if (pm[i]) io[i % 5] = 1'b1;
    io[5] = timer_i;
    int_q.push_back(io);
    m_ep   = ((m_ep & ~clr) | (rise & m_mode)) & nmode;
    m_mask = nmask;
    m_mode = nmode;
    hist.push_front(irq_i);
    void'(hist.pop_back());
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) model_step();
  end

  initial forever begin
    @(negedge rst);
    model_reset();
  end

  // Monitor: pops expectations whenever the DUT has produced output.
  initial forever begin
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (int_q.size() > 0) check32("int_o", 32'(int_o), 32'(int_q.pop_front()));
    if (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      check32("rdata_model", rdata_o, e);
      if (dir_v.size() > 0) begin
        e = dir_v.pop_front();
        if (dir_c.pop_front()) check32(dir_n.pop_front(), rdata_o, e);
        else void'(dir_n.pop_front());
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(logic [2:0] r, logic [31:0] v);
    we_i = 1'b1;
    addr_i = {r, 2'b00};
    wdata_i = v;
    @(negedge clk);
    we_i = 1'b0;
  endtask

  task automatic rd(logic [2:0] r, string nm, logic [31:0] v);
    re_i = 1'b1;
    addr_i = {r, 2'b00};
    dir_v.push_back(v);
    dir_c.push_back(1'b1);
    dir_n.push_back(nm);
    @(negedge clk);
    re_i = 1'b0;
  endtask

  task automatic chk_int(string nm, logic [5:0] e);
    check32(nm, 32'(int_o), 32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    tick(2);
    chk_int("reset_int", 6'b0);
    check32("reset_rdata", rdata_o, 32'h0);
    rst = 1'b1;

    wr(R_MODE, 32'h00);
    wr(R_MASK, 32'h01);
    irq_i[0] = 1'b1;
    tick(2);
    chk_int("level_early", 6'b000000);
    tick(1);
    chk_int("level_rise", 6'b000001);
    irq_i[0] = 1'b0;
    tick(2);
    chk_int("level_hold", 6'b000001);
    tick(1);
    chk_int("level_fall", 6'b000000);

    wr(R_MODE, 32'hFF);
    wr(R_MASK, 32'hFF);
    irq_i[6] = 1'b1;
    tick(1);
    irq_i[6] = 1'b0;
    tick(3);
    chk_int("edge_set", 6'b000010);
    tick(3);
    chk_int("edge_persist", 6'b000010);
    rd(R_CLAIM, "claim6", 32'h8000_0006);
    tick(1);
    chk_int("claim6_clr", 6'b000000);
    rd(R_CLAIM, "claim_empty", 32'h0);

    irq_i[2] = 1'b1;
    irq_i[7] = 1'b1;
    tick(1);
    irq_i = '0;
    tick(3);
    chk_int("prio_line2", 6'b000100);
    rd(R_CLAIM, "claim2", 32'h8000_0002);
    rd(R_CLAIM, "claim7", 32'h8000_0007);
    tick(1);
    chk_int("prio_done", 6'b000000);

    irq_i[3] = 1'b1;
    tick(2);
    wr(R_CLEAR, 32'h08);
    irq_i[3] = 1'b0;
    rd(R_PEND, "collide_pend", 32'h08);
    wr(R_CLEAR, 32'h08);
    rd(R_PEND, "cleared_pend", 32'h00);

    wr(R_MASK, 32'h00);
    irq_i[0] = 1'b1;
    tick(1);
    irq_i[0] = 1'b0;
    tick(4);
    chk_int("masked_int", 6'b000000);
    rd(R_PEND, "masked_pend", 32'h01);
    timer_i = 1'b1;
    tick(1);
    chk_int("timer_line", 6'b100000);
    wr(R_MASK, 32'h01);
    tick(1);
    chk_int("unmask_int", 6'b100001);
    timer_i = 1'b0;
    tick(1);

    #2;
    rst = 1'b0;
    #1;
    chk_int("arst_int", 6'b000000);
    check32("arst_rdata", rdata_o, 32'h0);
    irq_i[4] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    tick(4);
    rd(R_MASK, "arst_mask", 32'h0);
    rd(R_MODE, "arst_mode", 32'h0);
    wr(R_MODE, 32'hFF);
    wr(R_MASK, 32'hFF);
    tick(3);
    rd(R_PEND, "held_high_pend", 32'h0);
    chk_int("held_high_int", 6'b000000);
    irq_i[4] = 1'b0;
    tick(3);

    for (int n = 0; n < 600; n++) begin
      irq_i   = irq_i ^ NS'($urandom & $urandom & $urandom);
      timer_i = 1'($urandom_range(0, 1));
      we_i    = ($urandom_range(0, 3) == 0);
      re_i    = ($urandom_range(0, 2) == 0);
      addr_i  = 5'($urandom);
      wdata_i = $urandom;
      @(negedge clk);
    end
    we_i = 1'b0;
    re_i = 1'b0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- External interrupt controller directly upstream of the CP0 register file; drives its 6-bit hardware interrupt input (int_i).
- Synchronises NUM_SRC asynchronous device lines and detects level or rising-edge events per source.
- Latches pending state, applies a mask, and routes enabled sources onto CPU lines 0..4.
- Registers CP0's timer interrupt onto line 5; software reaches it through a small word-addressed register port.

Parameters:
- NUM_SRC, 8, number of external sources (1..32)
- SYNC_STAGES, 2, synchroniser depth (>=2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- irq_i  in  NUM_SRC  raw asynchronous device interrupt lines
- timer_i  in  1  CP0 timer interrupt (clk domain)
- we_i  in  1  register write strobe
- re_i  in  1  register read strobe
- addr_i  in  5  byte address; bits [4:2] select register, [1:0] ignored
- wdata_i  in  32  write data
- rdata_o  out  32  read data, valid the cycle after re_i
- int_o  out  6  to CP0 int_i

Behaviour:
- Reset (rst=0, asynchronous): all sync flops, pending, MASK, MODE, rdata_o and int_o clear to 0.
- Synchroniser: s = last stage of the SYNC_STAGES chain; d = s delayed one more cycle.
- Per source i, MODE[i] selects detection: 0 = level, 1 = rising edge.
- Edge detect: rise[i] = s[i] & ~d[i].
- Edge pending set: ep[i] <= 1 on rise[i] when MODE[i]=1.
- Edge pending clear: CLEAR write of 1 at bit i, or CLAIM of index i.
- Set beats clear in the same cycle; a new event is never lost.
- While MODE[i]=0, ep[i] is forced to 0.
- pend[i] = MODE[i] ? ep[i] : s[i].
- Route: line k (0..4) = OR of (pend[i] & MASK[i]) over all i with i mod 5 == k.
- int_o[4:0] <= route each cycle; int_o[5] <= timer_i.
- Latency, with SYNC_STAGES=2 and the input meeting setup at edge E1:
  - level source: int_o asserts after E3
  - edge source: int_o asserts after E4
  - timer_i: 1 cycle
- Register map (addr_i[4:2]); writes take effect at the edge that samples we_i:
  - 0 PENDING: RO, pend.
  - 1 MASK: RW, bits beyond NUM_SRC read 0.
  - 2 MODE: RW. Writing a 1->0 change drops that ep bit; a 0->1 change starts with ep=0.
  - 3 CLEAR: WO, write-1-to-clear ep; reads 0.
  - 4 CLAIM: RO with side effect. Returns {1'b1, 26'b0, idx[4:0]} for the lowest-index i with pend&MASK set, else 0. On re_i it clears ep[idx] at the same edge that captures rdata_o. A level source is not cleared by a claim.
  - 5 RAW: RO, s.
  - 6..7: read 0, writes ignored.
- rdata_o holds its value until the next re_i.
- we_i and re_i in the same cycle: both execute. The read returns pre-write contents, and a CLEAR/claim collision on the same bit clears it once.
- Lines with no routed source (NUM_SRC<5) stay 0.
- Reset asserted mid-operation: everything clears immediately. After release, rising edges need a full synchroniser pass and d must first see 0, so an input already high at release in edge mode does not fire.

Decomposition:
- Constants in the shared defines file:
  - register offsets INTC_REG_PENDING..INTC_REG_RAW
  - claim-valid bit position
  - CPU interrupt line count (6)
  - timer line index (5)
- One sub-module: irq_sync, a parameterised width × SYNC_STAGES flop chain with asynchronous active-low clear, instantiated once for all NUM_SRC bits.

Test Plan:
- Level: MODE=0, MASK=0x01, raise irq_i[0] -> int_o=6'b000001 three edges later; drop irq_i[0] -> int_o returns to 0 after the same latency.
- Edge + claim: MODE=0xFF, MASK=0xFF, pulse irq_i[6] for 1 cycle -> int_o[1]=1 persists (6 mod 5=1). Read CLAIM -> rdata_o=0x80000006, int_o[1]=0 next cycle. Second CLAIM read -> 0x00000000.
- Priority/route: edge pulses on sources 2 and 7 -> int_o[2]=1. First CLAIM returns 0x80000002, second returns 0x80000007, then int_o=0.
- Set-vs-clear collision: rise on source 3 in the same cycle as a CLEAR write of 0x08 -> PENDING bit 3 remains 1.
- Mask/timer: MASK=0, pulse irq_i[0] -> int_o[0]=0 while PENDING reads 0x01. timer_i=1 -> int_o[5]=1 one cycle later. Then MASK=0x01 -> int_o[0]=1 one cycle after the write.
- Async reset: pull rst low mid-pending, between clock edges -> int_o, rdata_o, MASK and MODE read 0 immediately. irq_i[4] held high across release in edge mode -> no pending.
